// File: rtl/vga_timing_gen_if.sv
// Video output bundle: pixel clock, syncs, active-region flag and 24-bit colour.
interface video_if;
    logic        CLK;
    logic        HS;
    logic        VS;
    logic        BLANK;
    logic [23:0] RGB;

    modport master (output CLK, HS, VS, BLANK, RGB);
    modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator with grid, colour-bar, stream and solid test patterns.
// Define VGA_FRAME_CNT_EN to add the frame_cnt output and its counter.
module vga_timing_gen #(
    parameter int HDISP     = 800,
    parameter int VDISP     = 480,
    parameter int HFP       = 40,
    parameter int HPULSE    = 48,
    parameter int HBP       = 40,
    parameter int VFP       = 13,
    parameter int VPULSE    = 3,
    parameter int VBP       = 29,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int GRID_LOG2 = 4
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        sof,
    output logic        underflow,
    input  logic        underflow_clr,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
`endif
    video_if.master     video_ifm
);

    localparam int HTOT   = HDISP + HFP + HPULSE + HBP;
    localparam int VTOT   = VDISP + VFP + VPULSE + VBP;
    localparam int HSTART = HFP + HPULSE + HBP;
    localparam int VSTART = VFP + VPULSE + VBP;
    localparam int HW     = $clog2(HTOT);
    localparam int VW     = $clog2(VTOT);
    localparam int BAR_W  = (HDISP >= 8) ? (HDISP / 8) : 1;
    localparam int GRID_MASK = (1 << GRID_LOG2) - 1;

    localparam logic [HW-1:0] H_LAST    = HW'(HTOT - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(VTOT - 1);
    localparam logic [HW-1:0] H_SYNC_S  = HW'(HFP);
    localparam logic [HW-1:0] H_SYNC_E  = HW'(HFP + HPULSE);
    localparam logic [VW-1:0] V_SYNC_S  = VW'(VFP);
    localparam logic [VW-1:0] V_SYNC_E  = VW'(VFP + VPULSE);
    localparam logic [HW-1:0] H_START   = HW'(HSTART);
    localparam logic [VW-1:0] V_START   = VW'(VSTART);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [1:0]    r_mode_q;
    logic          r_hs;
    logic          r_vs;
    logic          r_blank;
    logic [23:0]   r_rgb;
    logic          r_sof;
    logic          r_underflow;

    logic          w_wrap;
    logic          w_origin;
    logic          w_active;
    logic [HW-1:0] w_x;
    logic [VW-1:0] w_y;
    logic [HW-1:0] w_bar_q;
    logic [2:0]    w_bar;
    logic          w_grid;
    logic          w_starve;
    logic [23:0]   w_bar_rgb;
    logic [23:0]   w_rgb;

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
        end else begin
            r_h <= r_h + HW'(1);
        end
    end

    always_comb begin
        w_wrap   = (r_h == H_LAST) && (r_v == V_LAST);
        w_origin = (r_h == '0) && (r_v == '0);
        w_active = (r_h >= H_START) && (r_v >= V_START);
        w_x      = r_h - H_START;
        w_y      = r_v - V_START;
        w_grid   = ((w_x & HW'(GRID_MASK)) == '0) || ((w_y & VW'(GRID_MASK)) == '0);
        w_bar_q  = w_x / HW'(BAR_W);
        w_bar    = (w_bar_q > HW'(7)) ? 3'd7 : w_bar_q[2:0];
    end

    always_comb begin
        w_bar_rgb = 24'h000000;
        case (w_bar)
            3'd0:    w_bar_rgb = 24'hFFFFFF;
            3'd1:    w_bar_rgb = 24'hFFFF00;
            3'd2:    w_bar_rgb = 24'h00FFFF;
            3'd3:    w_bar_rgb = 24'h00FF00;
            3'd4:    w_bar_rgb = 24'hFF00FF;
            3'd5:    w_bar_rgb = 24'hFF0000;
            3'd6:    w_bar_rgb = 24'h0000FF;
            default: w_bar_rgb = 24'h000000;
        endcase
    end

    // Stream handshake: pix_ready is a combinational function of position and
    // mode only; a pixel transfers on a cycle with pix_valid && pix_ready, and
    // a ready cycle without valid is a starved pixel (black, never retried).
    assign pix_ready = (r_mode_q == 2'd2) && w_active;
    assign w_starve  = pix_ready && !pix_valid;

    always_comb begin
        w_rgb = 24'h000000;
        if (w_active) begin
            case (r_mode_q)
                2'd0:    w_rgb = w_grid ? 24'hFFFFFF : 24'h000000;
                2'd1:    w_rgb = w_bar_rgb;
                2'd2:    w_rgb = pix_valid ? pix_data : 24'h000000;
                default: w_rgb = solid_rgb;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            r_mode_q    <= 2'd0;
            r_hs        <= ~HS_POL;
            r_vs        <= ~VS_POL;
            r_blank     <= 1'b0;
            r_rgb       <= 24'h000000;
            r_sof       <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_origin) begin
                r_mode_q <= mode;
            end
            r_hs    <= ((r_h >= H_SYNC_S) && (r_h < H_SYNC_E)) ? HS_POL : ~HS_POL;
            r_vs    <= ((r_v >= V_SYNC_S) && (r_v < V_SYNC_E)) ? VS_POL : ~VS_POL;
            r_blank <= w_active;
            r_rgb   <= w_rgb;
            r_sof   <= w_origin;
            // A new starvation event outranks a clear in the same cycle.
            if (w_starve) begin
                r_underflow <= 1'b1;
            end else if (underflow_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            r_frame_cnt <= 16'd0;
        end else if (w_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign sof       = r_sof;
    assign underflow = r_underflow;

    assign video_ifm.CLK   = pixel_clk;
    assign video_ifm.HS    = r_hs;
    assign video_ifm.VS    = r_vs;
    assign video_ifm.BLANK = r_blank;
    assign video_ifm.RGB   = r_rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen: a position-based reference model queues
// the expected registered outputs each cycle, a monitor pops and compares them.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int HDISP  = 16;
    localparam int VDISP  = 4;
    localparam int HFP    = 2;
    localparam int HPULSE = 2;
    localparam int HBP    = 2;
    localparam int VFP    = 1;
    localparam int VPULSE = 1;
    localparam int VBP    = 1;
    localparam int GRID   = 4;
    localparam int HTOT   = 22;
    localparam int VTOT   = 7;
    localparam int FTOT   = HTOT * VTOT;
    localparam int HSTART = 6;
    localparam int VSTART = 3;
    localparam int W      = 45;

    typedef struct packed {
        logic        sof;
        logic        hs;
        logic        vs;
        logic        blank;
        logic [23:0] rgb;
        logic        uf;
        logic [15:0] fc;
    } vid_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic [23:0] pix_data = 24'h0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        sof;
    logic        underflow;
    logic        underflow_clr = 1'b0;
    logic [15:0] fc_got;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    assign fc_got = frame_cnt;
`else
    assign fc_got = 16'h0;
`endif

    video_if vif ();

    vga_timing_gen #(
        .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(1'b0), .VS_POL(1'b0),
        .GRID_LOG2(2)
    ) dut (
        .pixel_clk(clk),
        .pixel_rst_n(rst_n),
        .mode(mode),
        .solid_rgb(solid_rgb),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .sof(sof),
        .underflow(underflow),
        .underflow_clr(underflow_clr),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .video_ifm(vif)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    int           m_pos = 0;
    logic [1:0]   m_mode_q = 2'd0;
    logic         m_uf = 1'b0;
    logic [15:0]  m_fc = 16'd0;
    int           n_vec = 0;
    int           n_err = 0;
    int           data_cnt = 0;

    function automatic logic active_at(input int pos);
        return ((pos % HTOT) >= HSTART) && ((pos / HTOT) >= VSTART);
    endfunction

    function automatic logic [23:0] bar_colour(input int idx);
        logic [23:0] lut [8];
        lut = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return lut[(idx > 7) ? 7 : idx];
    endfunction

    function automatic vid_t reset_word();
        vid_t r;
        r = '0;
        r.hs = 1'b1;
        r.vs = 1'b1;
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_pos    = 0;
                m_mode_q = 2'd0;
                m_uf     = 1'b0;
                m_fc     = 16'd0;
                exp_q.push_back(reset_word());
            end else begin
                int h, v, x, y;
                logic act;
                vid_t e;
                h   = m_pos % HTOT;
                v   = m_pos / HTOT;
                x   = h - HSTART;
                y   = v - VSTART;
                act = active_at(m_pos);
                e.sof   = (m_pos == 0);
                e.hs    = !((h >= HFP) && (h < HFP + HPULSE));
                e.vs    = !((v >= VFP) && (v < VFP + VPULSE));
                e.blank = act;
                e.rgb   = 24'h0;
                if (act) begin
                    case (m_mode_q)
                        2'd0: e.rgb = ((x % GRID == 0) || (y % GRID == 0)) ? 24'hFFFFFF : 24'h0;
                        2'd1: e.rgb = bar_colour(x / (HDISP / 8));
                        2'd2: e.rgb = pix_valid ? pix_data : 24'h0;
                        default: e.rgb = solid_rgb;
                    endcase
                end
                if (act && m_mode_q == 2'd2 && !pix_valid) m_uf = 1'b1;
                else if (underflow_clr) m_uf = 1'b0;
                if (m_pos == FTOT - 1) m_fc = m_fc + 16'd1;
                if (m_pos == 0) m_mode_q = mode;
                e.uf = m_uf;
`ifdef VGA_FRAME_CNT_EN
                e.fc = m_fc;
`else
                e.fc = 16'h0;
`endif
                exp_q.push_back(e);
                m_pos = (m_pos + 1) % FTOT;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        @(posedge clk);
        forever begin
            vid_t got, e;
            logic exp_rdy;
            @(negedge clk);
            got = {sof, vif.HS, vif.VS, vif.BLANK, vif.RGB, underflow, fc_got};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL queue_empty t=%0t: output seen with no expectation", $time);
            end else begin
                e = exp_q.pop_front();
                if (!rst_n) e = reset_word();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL video t=%0t got sof=%b hs=%b vs=%b blank=%b rgb=%h uf=%b fc=%0d exp sof=%b hs=%b vs=%b blank=%b rgb=%h uf=%b fc=%0d",
                             $time, got.sof, got.hs, got.vs, got.blank, got.rgb, got.uf, got.fc,
                             e.sof, e.hs, e.vs, e.blank, e.rgb, e.uf, e.fc);
                end
            end
            exp_rdy = rst_n && (m_mode_q == 2'd2) && active_at(m_pos);
            n_vec++;
            if (pix_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL pix_ready t=%0t got=%b exp=%b", $time, pix_ready, exp_rdy);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_cycles(input int n, input int valid_pct, input int clr_pct);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pix_data      = 24'(data_cnt);
            data_cnt      = data_cnt + 1;
            pix_valid     = ($urandom_range(0, 99) < valid_pct);
            underflow_clr = ($urandom_range(0, 99) < clr_pct);
        end
    endtask

    task automatic wait_pos(input int pos);
        int i;
        i = 0;
        while (m_pos != pos && i < 2 * FTOT) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (m_pos != pos) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_pos got=%0d exp=%0d", m_pos, pos);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        mode = 2'd0;
        run_cycles(2 * FTOT, 100, 0);

        mode = 2'd1;
        run_cycles(FTOT + FTOT / 2, 100, 0);
        mode      = 2'd3;
        solid_rgb = 24'($urandom);
        run_cycles(FTOT, 100, 0);

        mode = 2'd2;
        run_cycles(2 * FTOT, 100, 0);
        run_cycles(3 * FTOT, 90, 3);

        for (int k = 0; k < 8; k++) begin
            mode      = 2'($urandom_range(0, 3));
            solid_rgb = 24'($urandom);
            run_cycles($urandom_range(50, 200), 80, 10);
        end

        mode = 2'd2;
        wait_pos(5 * HTOT + 10);
        rst_n = 1'b0;
        run_cycles(2, 100, 0);
        rst_n = 1'b1;
        run_cycles(2 * FTOT + 5, 95, 5);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter HDISP, default 800, active pixels per line.
REQ-002 Parameter VDISP, default 480, active lines per frame.
REQ-003 Parameters HFP/HPULSE/HBP, defaults 40/48/40, horizontal front porch/sync/back porch in pixels.
REQ-004 Parameters VFP/VPULSE/VBP, defaults 13/3/29, vertical front porch/sync/back porch in lines.
REQ-005 Parameters HS_POL/VS_POL, default 0/0, asserted sync level; GRID_LOG2, default 4, grid pitch = 2**GRID_LOG2.
REQ-006 pixel_clk  input  1  pixel clock; all logic on rising edge.
REQ-007 pixel_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 mode  input  2  pattern select: 0 grid, 1 colour bars, 2 stream, 3 solid.
REQ-009 solid_rgb  input  24  colour for mode 3.
REQ-010 pix_data  input  24  stream pixel; pix_valid input 1; pix_ready output 1.
REQ-011 sof  output  1  one-cycle start-of-frame pulse.
REQ-012 underflow  output  1  sticky stream-starvation flag; underflow_clr input 1 clears it.
REQ-013 video_ifm  video_if.master  -  CLK, HS, VS, BLANK, RGB[23:0]; CLK driven by pixel_clk.

Function
REQ-014 h counter 0..HTOT-1 (HTOT=HDISP+HFP+HPULSE+HBP), wraps to 0 and increments v; v 0..VTOT-1, wraps to 0 at end of last line.
REQ-015 Line/frame order: front porch, sync, back porch, then active region; HSTART=HFP+HPULSE+HBP, VSTART=VFP+VPULSE+VBP.
REQ-016 Active when h>=HSTART and v>=VSTART; x=h-HSTART, y=v-VSTART.
REQ-017 All video outputs registered: values for counter position (h,v) appear one cycle after the counter holds (h,v).
REQ-018 HS = HS_POL when HFP<=h<HFP+HPULSE, else ~HS_POL; VS likewise with v, VFP, VPULSE, VS_POL.
REQ-019 BLANK = 1 in active region, 0 otherwise; RGB = 0 whenever not active.
REQ-020 mode sampled into mode_q only when h=0 and v=0; mid-frame changes take effect next frame.
REQ-021 Grid: RGB=FFFFFF when x[GRID_LOG2-1:0]==0 or y[GRID_LOG2-1:0]==0, else 000000.
REQ-022 Bars: bar index = x/(HDISP/8) saturated at 7; colours 0..7 = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-023 Solid: RGB=solid_rgb.
REQ-024 Stream: pix_ready combinational, high iff mode_q==2 and active; transfer when pix_valid&pix_ready, RGB=pix_data next cycle.
REQ-025 Stream starvation: pix_ready high and pix_valid low -> RGB=000000 for that pixel, underflow set; no pixel held over.
REQ-026 Simultaneous underflow set and underflow_clr: set wins.
REQ-027 sof asserted (registered) for the pixel at h=0,v=0, i.e. the cycle HS/VS/BLANK for that position appear.

Reset
REQ-028 While pixel_rst_n low: h=v=0, mode_q=0, HS=~HS_POL, VS=~VS_POL, BLANK=0, RGB=0, sof=0, underflow=0, frame_cnt=0.
REQ-029 Reset asserted mid-frame takes effect immediately; after release, counting restarts at h=0,v=0 and first sof follows in the next cycle.

Configuration
REQ-030 Macro VGA_FRAME_CNT_EN defined: output frame_cnt[15:0], increments (wrapping at FFFF->0) on each counter wrap to h=0,v=0 after a full frame; not incremented on first frame after reset.
REQ-031 VGA_FRAME_CNT_EN undefined: frame_cnt port and counter absent; all other behaviour identical.

Verification (HDISP=16,VDISP=4,HFP=2,HPULSE=2,HBP=2,VFP=1,VPULSE=1,VBP=1,GRID_LOG2=2; HTOT=22,VTOT=7)
REQ-032 Release reset, run 2 frames -> sof every 154 cycles, HS low for cycles h=2..3, VS low for line 1, BLANK high 16 cycles on lines 3..6 only.
REQ-033 mode=0 -> active line y=0 all FFFFFF; y=1 FFFFFF at x=0,4,8,12, else 000000.
REQ-034 mode=1 -> x=0..1 FFFFFF, x=2..3 FFFF00, ..., x=14..15 000000; mode switched to 3 mid-frame -> change only after next sof.
REQ-035 mode=2, pix_valid held high with pix_data=incrementing count -> 64 transfers/frame, RGB equals sent data one cycle later; drop pix_valid for one active pixel -> RGB 000000, underflow=1 until underflow_clr.
REQ-036 Reset pulsed at h=10,v=5 -> all outputs at reset values immediately, next sof one cycle after release; with VGA_FRAME_CNT_EN, frame_cnt=0 then 1 after first complete frame.
